// File: rtl/lcd_pkg.sv
// Shared encodings for the character LCD controller: request kinds, HD44780 command bytes,
// controller/strobe state enums, DDRAM row base and the power-on init table.
package lcd_pkg;

  typedef enum logic [1:0] {
    KIND_CHAR   = 2'b00,
    KIND_CURSOR = 2'b01,
    KIND_RAW    = 2'b10,
    KIND_CLEAR  = 2'b11
  } req_kind_e;

  localparam logic [7:0] FUNC_8B   = 8'h38;
  localparam logic [7:0] FUNC_4B   = 8'h28;
  localparam logic [7:0] DISP_ON   = 8'h0C;
  localparam logic [7:0] ENTRY     = 8'h06;
  localparam logic [7:0] CLEAR     = 8'h01;
  localparam logic [7:0] HOME      = 8'h02;
  localparam logic [7:0] SET_DDRAM = 8'h80;

  typedef enum logic [2:0] {
    ST_POR_WAIT, ST_INIT, ST_IDLE, ST_ADDR, ST_WRITE, ST_CLR_WAIT, ST_DONE
  } state_e;

  typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_HIGH, PH_LOW} phase_e;

  function automatic logic [7:0] row_base(input logic [1:0] row, input logic [7:0] ncols);
    case (row)
      2'd0:    return 8'h00;
      2'd1:    return 8'h40;
      2'd2:    return ncols;
      default: return 8'h40 + ncols;
    endcase
  endfunction

  // Returns {nibble_only, byte}; 4-bit mode starts with four lone high nibbles.
  function automatic logic [8:0] init_entry(input logic [2:0] step, input logic four_bit);
    if (four_bit) begin
      case (step)
        3'd0, 3'd1, 3'd2: return {1'b1, 8'h30};
        3'd3:             return {1'b1, 8'h20};
        3'd4:             return {1'b0, FUNC_4B};
        3'd5:             return {1'b0, DISP_ON};
        3'd6:             return {1'b0, ENTRY};
        default:          return {1'b0, CLEAR};
      endcase
    end else begin
      case (step)
        3'd0:    return {1'b0, FUNC_8B};
        3'd1:    return {1'b0, DISP_ON};
        3'd2:    return {1'b0, ENTRY};
        default: return {1'b0, CLEAR};
      endcase
    end
  endfunction

endpackage

// File: rtl/lcd_char_ctrl_if.sv
// Request/status bundle between the CPU port decoder (master) and the LCD controller (slave).
interface lcd_char_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_kind;
  logic [7:0] req_data;
  logic [1:0] req_row;
  logic [5:0] req_col;
  logic       done_tick;
  logic       init_done;

  modport master (
    output req_valid, req_kind, req_data, req_row, req_col,
    input  req_ready, done_tick, init_done
  );

  modport slave (
    input  req_valid, req_kind, req_data, req_row, req_col,
    output req_ready, done_tick, init_done
  );
endinterface

// File: rtl/lcd_strobe.sv
// EN strobe engine: setup / EN high / EN low, HOLD_CYCLES each; 4-bit bus sends high then low nibble.
// A start may coincide with the done pulse of the previous transfer, giving back-to-back strobes.
module lcd_strobe
  import lcd_pkg::*;
#(
  parameter int BUS_WIDTH   = 8,
  parameter int HOLD_CYCLES = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rs_i,
  input  logic [7:0] data_i,
  input  logic       nibble_only,
  output logic       done,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic [7:0] lcd_data
);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);

  phase_e        phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    dat_q, dat_d;
  logic          rs_q, rs_d, nib_q, nib_d, lo_q, lo_d;

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    dat_d   = dat_q;
    rs_d    = rs_q;
    nib_d   = nib_q;
    lo_d    = lo_q;
    done    = 1'b0;
    if (phase_q != PH_IDLE) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        case (phase_q)
          PH_SETUP: phase_d = PH_HIGH;
          PH_HIGH:  phase_d = PH_LOW;
          default: begin
            if (BUS_WIDTH == 4 && !nib_q && !lo_q) begin
              lo_d    = 1'b1;
              phase_d = PH_SETUP;
            end else begin
              done    = 1'b1;
              phase_d = PH_IDLE;
              dat_d   = '0;
              rs_d    = 1'b0;
              nib_d   = 1'b0;
              lo_d    = 1'b0;
            end
          end
        endcase
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    if (start) begin
      phase_d = PH_SETUP;
      cnt_d   = '0;
      dat_d   = data_i;
      rs_d    = rs_i;
      nib_d   = nibble_only;
      lo_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= PH_IDLE;
      cnt_q   <= '0;
      dat_q   <= '0;
      rs_q    <= 1'b0;
      nib_q   <= 1'b0;
      lo_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      dat_q   <= dat_d;
      rs_q    <= rs_d;
      nib_q   <= nib_d;
      lo_q    <= lo_d;
    end
  end

  assign lcd_en   = (phase_q == PH_HIGH);
  assign lcd_rs   = rs_q;
  assign lcd_data = (BUS_WIDTH == 8) ? dat_q
                  : (lo_q ? {dat_q[3:0], 4'h0} : {dat_q[7:4], 4'h0});
endmodule

// File: rtl/lcd_char_ctrl.sv
// HD44780-class LCD controller: power-on init, then one valid/ready request at a time, done_tick on completion.
// Define LCD_AUTOWRAP_EN to track the cursor and re-address the next row after a char in the last column.
module lcd_char_ctrl
  import lcd_pkg::*;
#(
  parameter int BUS_WIDTH    = 8,
  parameter int HOLD_CYCLES  = 500,
  parameter int POR_CYCLES   = 20000,
  parameter int CLEAR_CYCLES = 80000,
  parameter int NUM_ROWS     = 2,
  parameter int NUM_COLS     = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  lcd_char_ctrl_if.slave req_if,
  output logic [7:0]     lcd_data,
  output logic           lcd_rs,
  output logic           lcd_rw,
  output logic           lcd_en
);
  if (BUS_WIDTH != 8 && BUS_WIDTH != 4) begin : g_bad_bus
    $error("lcd_char_ctrl: BUS_WIDTH must be 8 or 4");
  end

  localparam logic        FOUR_BIT  = (BUS_WIDTH == 4);
  localparam logic [2:0]  LAST_STEP = FOUR_BIT ? 3'd7 : 3'd3;
  localparam logic [31:0] POR_LAST  = 32'(POR_CYCLES - 1);
  localparam logic [31:0] CLR_LAST  = 32'(CLEAR_CYCLES - 1);
  localparam logic [7:0]  NCOLS     = 8'(NUM_COLS);

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  step_q, step_d;
  req_kind_e   kind_q, kind_d;
  logic [7:0]  dat_q, dat_d;
  logic        init_done_q, init_done_d, wrap_q, wrap_d;
`ifdef LCD_AUTOWRAP_EN
  logic [1:0]  row_q, row_d;
  logic [5:0]  col_q, col_d;
`endif

  logic        st_start, st_rs, st_nib, st_done, ready_c, done_c, clr_cmd;
  logic [7:0]  st_data;
  logic [8:0]  init_ent;
  logic [1:0]  row_cl;
  logic [5:0]  col_cl;

  lcd_strobe #(.BUS_WIDTH(BUS_WIDTH), .HOLD_CYCLES(HOLD_CYCLES)) u_strobe (
    .clk, .rst_n, .start(st_start), .rs_i(st_rs), .data_i(st_data), .nibble_only(st_nib),
    .done(st_done), .lcd_en, .lcd_rs, .lcd_data
  );

  always_comb begin
    state_d = state_q;  cnt_d = cnt_q;  step_d = step_q;  kind_d = kind_q;  dat_d = dat_q;
    init_done_d = init_done_q;  wrap_d = wrap_q;
`ifdef LCD_AUTOWRAP_EN
    row_d = row_q;  col_d = col_q;
`endif
    st_start = 1'b0;  st_rs = 1'b0;  st_nib = 1'b0;  st_data = '0;
    ready_c  = 1'b0;  done_c = 1'b0;
    init_ent = init_entry((state_q == ST_POR_WAIT) ? 3'd0 : step_q + 3'd1, FOUR_BIT);
    row_cl   = (int'(req_if.req_row) >= NUM_ROWS) ? 2'(NUM_ROWS - 1) : req_if.req_row;
    col_cl   = (int'(req_if.req_col) >= NUM_COLS) ? 6'(NUM_COLS - 1) : req_if.req_col;
    clr_cmd  = (kind_q == KIND_CLEAR) || (kind_q == KIND_RAW && (dat_q == CLEAR || dat_q == HOME));
    case (state_q)
      ST_POR_WAIT: begin
        if (cnt_q == POR_LAST) begin
          state_d  = ST_INIT;  cnt_d = '0;  step_d = '0;
          st_start = 1'b1;     {st_nib, st_data} = init_ent;
        end else cnt_d = cnt_q + 32'd1;
      end
      ST_INIT: begin
        if (st_done) begin
          if (step_q == LAST_STEP) begin
            state_d = ST_CLR_WAIT;  cnt_d = '0;
          end else begin
            step_d   = step_q + 3'd1;
            st_start = 1'b1;  {st_nib, st_data} = init_ent;
          end
        end
      end
      ST_IDLE: begin
        ready_c = 1'b1;
        if (req_if.req_valid) begin
          kind_d   = req_kind_e'(req_if.req_kind);
          dat_d    = req_if.req_data;
          st_start = 1'b1;
          state_d  = ST_WRITE;
          case (req_kind_e'(req_if.req_kind))
            KIND_CHAR: begin
              st_rs = 1'b1;  st_data = req_if.req_data;
`ifdef LCD_AUTOWRAP_EN
              wrap_d = (col_q == 6'(NUM_COLS - 1));
              col_d  = wrap_d ? 6'd0 : col_q + 6'd1;
              if (wrap_d) row_d = (row_q == 2'(NUM_ROWS - 1)) ? 2'd0 : row_q + 2'd1;
`endif
            end
            KIND_CURSOR: begin
              state_d = ST_ADDR;
              st_data = SET_DDRAM | (row_base(row_cl, NCOLS) + {2'b00, col_cl});
`ifdef LCD_AUTOWRAP_EN
              row_d = row_cl;  col_d = col_cl;
`endif
            end
            KIND_RAW: begin
              st_data = req_if.req_data;
`ifdef LCD_AUTOWRAP_EN
              if (req_if.req_data == CLEAR || req_if.req_data == HOME) begin
                row_d = '0;  col_d = '0;
              end
`endif
            end
            default: begin
              st_data = CLEAR;
`ifdef LCD_AUTOWRAP_EN
              row_d = '0;  col_d = '0;
`endif
            end
          endcase
        end
      end
      ST_WRITE: begin
        if (st_done) begin
          if (clr_cmd) begin
            state_d = ST_CLR_WAIT;  cnt_d = '0;
          end else if (wrap_q) begin
            // Cursor was already advanced at accept; column is 0 on the new row.
            state_d = ST_ADDR;  wrap_d = 1'b0;  st_start = 1'b1;
`ifdef LCD_AUTOWRAP_EN
            st_data = SET_DDRAM | row_base(row_q, NCOLS);
`endif
          end else state_d = ST_DONE;
        end
      end
      ST_ADDR:     if (st_done) state_d = ST_DONE;
      ST_CLR_WAIT: begin
        if (cnt_q == CLR_LAST) begin
          state_d     = init_done_q ? ST_DONE : ST_IDLE;
          init_done_d = 1'b1;
        end else cnt_d = cnt_q + 32'd1;
      end
      ST_DONE: begin
        done_c  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_POR_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_POR_WAIT;  cnt_q <= '0;  step_q <= '0;  kind_q <= KIND_CHAR;  dat_q <= '0;
      init_done_q <= 1'b0;  wrap_q <= 1'b0;
`ifdef LCD_AUTOWRAP_EN
      row_q <= '0;  col_q <= '0;
`endif
    end else begin
      state_q <= state_d;  cnt_q <= cnt_d;  step_q <= step_d;  kind_q <= kind_d;  dat_q <= dat_d;
      init_done_q <= init_done_d;  wrap_q <= wrap_d;
`ifdef LCD_AUTOWRAP_EN
      row_q <= row_d;  col_q <= col_d;
`endif
    end
  end

  assign req_if.req_ready = ready_c;
  assign req_if.done_tick = done_c;
  assign req_if.init_done = init_done_q;
  assign lcd_rw           = 1'b0;
endmodule

// File: tb/tb_lcd_char_ctrl.sv
// Directed bench: an 8-bit and a 4-bit controller with short timing, each under its own reset.
module tb_lcd_char_ctrl;
  localparam int HOLD = 4;
  localparam int POR  = 10;
  localparam int CLR  = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst8_n, rst4_n;
  lcd_char_ctrl_if if8 ();
  lcd_char_ctrl_if if4 ();
  logic [7:0] d8, d4;
  logic rs8, rs4, rw8, rw4, en8, en4;

  lcd_char_ctrl #(.BUS_WIDTH(8), .HOLD_CYCLES(HOLD), .POR_CYCLES(POR), .CLEAR_CYCLES(CLR),
                  .NUM_ROWS(2), .NUM_COLS(16)) dut8 (
    .clk(clk), .rst_n(rst8_n), .req_if(if8.slave),
    .lcd_data(d8), .lcd_rs(rs8), .lcd_rw(rw8), .lcd_en(en8));

  lcd_char_ctrl #(.BUS_WIDTH(4), .HOLD_CYCLES(HOLD), .POR_CYCLES(POR), .CLEAR_CYCLES(CLR),
                  .NUM_ROWS(2), .NUM_COLS(16)) dut4 (
    .clk(clk), .rst_n(rst4_n), .req_if(if4.slave),
    .lcd_data(d4), .lcd_rs(rs4), .lcd_rw(rw4), .lcd_en(en4));

  // Edge counter: read at a negedge it holds the index of the preceding posedge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  function automatic logic en_of(input bit sel);    return sel ? en4 : en8;                     endfunction
  function automatic logic rs_of(input bit sel);    return sel ? rs4 : rs8;                     endfunction
  function automatic logic rw_of(input bit sel);    return sel ? rw4 : rw8;                     endfunction
  function automatic logic [7:0] dat_of(input bit sel); return sel ? d4 : d8;                   endfunction
  function automatic logic rdy_of(input bit sel);   return sel ? if4.req_ready : if8.req_ready; endfunction
  function automatic logic done_of(input bit sel);  return sel ? if4.done_tick : if8.done_tick; endfunction
  function automatic logic init_of(input bit sel);  return sel ? if4.init_done : if8.init_done; endfunction

  task automatic drive(input bit sel, input logic v, input logic [1:0] k, input logic [7:0] d,
                       input logic [1:0] r, input logic [5:0] c);
    if (sel) begin
      if4.req_valid = v; if4.req_kind = k; if4.req_data = d; if4.req_row = r; if4.req_col = c;
    end else begin
      if8.req_valid = v; if8.req_kind = k; if8.req_data = d; if8.req_row = r; if8.req_col = c;
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accepting posedge.
  task automatic do_req(input bit sel, input logic [1:0] k, input logic [7:0] d, input logic [1:0] r,
                        input logic [5:0] c, output int t_acc, output bit ok);
    ok = 1'b0;
    t_acc = 0;
    for (int i = 0; i < 200; i++) begin
      if (rdy_of(sel)) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) return;
    drive(sel, 1'b1, k, d, r, c);
    @(negedge clk);
    t_acc = cyc;
    drive(sel, 1'b0, 2'b00, 8'h00, 2'b00, 6'd0);
  endtask

  task automatic catch_pulse(input bit sel, input int budget, output logic [7:0] d, output logic rs,
                             output int t_rise, output int t_fall, output bit ok);
    ok = 1'b0; d = '0; rs = 1'b0; t_rise = 0; t_fall = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (en_of(sel)) begin ok = 1'b1; break; end
    end
    if (!ok) return;
    d = dat_of(sel); rs = rs_of(sel); t_rise = cyc;
    ok = 1'b0;
    for (int i = 0; i < 4 * HOLD; i++) begin
      @(negedge clk);
      if (!en_of(sel)) begin ok = 1'b1; break; end
    end
    t_fall = cyc;
  endtask

  task automatic wait_done(input bit sel, input int budget, output int t, output bit ok);
    ok = 1'b0; t = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_of(sel)) begin ok = 1'b1; t = cyc; break; end
    end
  endtask

  task automatic test_reset();
    rst8_n = 1'b0; rst4_n = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 8'h00, 2'b00, 6'd0);
    drive(1'b1, 1'b0, 2'b00, 8'h00, 2'b00, 6'd0);
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      total++; if (rdy_of(s[0]) !== 1'b0)  begin bad++; $display("FAIL reset_ready sel=%0d got=%b exp=0", s, rdy_of(s[0])); end
      total++; if (done_of(s[0]) !== 1'b0) begin bad++; $display("FAIL reset_done sel=%0d got=%b exp=0", s, done_of(s[0])); end
      total++; if (init_of(s[0]) !== 1'b0) begin bad++; $display("FAIL reset_init sel=%0d got=%b exp=0", s, init_of(s[0])); end
      total++; if (en_of(s[0]) !== 1'b0)   begin bad++; $display("FAIL reset_en sel=%0d got=%b exp=0", s, en_of(s[0])); end
      total++; if (rs_of(s[0]) !== 1'b0)   begin bad++; $display("FAIL reset_rs sel=%0d got=%b exp=0", s, rs_of(s[0])); end
      total++; if (rw_of(s[0]) !== 1'b0)   begin bad++; $display("FAIL reset_rw sel=%0d got=%b exp=0", s, rw_of(s[0])); end
      total++; if (dat_of(s[0]) !== 8'h00) begin bad++; $display("FAIL reset_data sel=%0d got=%h exp=00", s, dat_of(s[0])); end
    end
  endtask

  // Expected pulse bytes and the cycle spacing are hand-derived from the strobe timing.
  task automatic run_init(input bit sel, input int npulse, input logic [7:0] exp_b[12]);
    logic [7:0] d; logic rs; int tr, tf, t_rel, t_init; bit ok;
    if (sel) rst4_n = 1'b1; else rst8_n = 1'b1;
    t_rel = cyc;
    tf = 0;
    for (int i = 0; i < npulse; i++) begin
      catch_pulse(sel, 100, d, rs, tr, tf, ok);
      total++; if (!ok) begin bad++; $display("FAIL init%0d_pulse%0d_seen got=timeout exp=pulse", sel ? 4 : 8, i); end
      total++; if (d !== exp_b[i]) begin bad++; $display("FAIL init%0d_data%0d got=%h exp=%h", sel ? 4 : 8, i, d, exp_b[i]); end
      total++; if (rs !== 1'b0)    begin bad++; $display("FAIL init%0d_rs%0d got=%b exp=0", sel ? 4 : 8, i, rs); end
      total++; if (tf - tr !== HOLD) begin bad++; $display("FAIL init%0d_en_width%0d got=%0d exp=%0d", sel ? 4 : 8, i, tf - tr, HOLD); end
      if (i == 0) begin
        total++; if (tr - t_rel !== POR + HOLD) begin bad++; $display("FAIL init%0d_first_rise got=%0d exp=%0d", sel ? 4 : 8, tr - t_rel, POR + HOLD); end
      end
    end
    total++; if (init_of(sel) !== 1'b0) begin bad++; $display("FAIL init%0d_early_done got=%b exp=0", sel ? 4 : 8, init_of(sel)); end
    t_init = -1;
    for (int i = 0; i < 100; i++) begin
      if (init_of(sel)) begin t_init = cyc; break; end
      @(negedge clk);
    end
    // EN-low tail of the strobe, then the clear wait.
    total++; if (t_init - tf !== HOLD + CLR) begin bad++; $display("FAIL init%0d_done_delay got=%0d exp=%0d", sel ? 4 : 8, t_init - tf, HOLD + CLR); end
    total++; if (rdy_of(sel) !== 1'b1) begin bad++; $display("FAIL init%0d_ready got=%b exp=1", sel ? 4 : 8, rdy_of(sel)); end
  endtask

  task automatic test_init8();
    logic [7:0] e[12] = '{8'h38, 8'h0C, 8'h06, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_init(1'b0, 4, e);
  endtask

  task automatic test_init4();
    logic [7:0] e[12] = '{8'h30, 8'h30, 8'h30, 8'h20, 8'h20, 8'h80, 8'h00, 8'hC0, 8'h00, 8'h60, 8'h00, 8'h10};
    run_init(1'b1, 12, e);
  endtask

  task automatic test_char8();
    logic [7:0] d; logic rs; int ta, tr, tf, td; bit ok;
    do_req(1'b0, 2'b00, 8'h41, 2'b00, 6'd0, ta, ok);
    total++; if (!ok) begin bad++; $display("FAIL char8_accept got=timeout exp=accepted"); end
    total++; if (if8.req_ready !== 1'b0) begin bad++; $display("FAIL char8_ready_busy got=%b exp=0", if8.req_ready); end
    catch_pulse(1'b0, 40, d, rs, tr, tf, ok);
    total++; if (d !== 8'h41) begin bad++; $display("FAIL char8_data got=%h exp=41", d); end
    total++; if (rs !== 1'b1) begin bad++; $display("FAIL char8_rs got=%b exp=1", rs); end
    total++; if (tr - ta !== HOLD) begin bad++; $display("FAIL char8_setup got=%0d exp=%0d", tr - ta, HOLD); end
    total++; if (tf - tr !== HOLD) begin bad++; $display("FAIL char8_en_width got=%0d exp=%0d", tf - tr, HOLD); end
    total++; if (if8.req_ready !== 1'b0) begin bad++; $display("FAIL char8_ready_mid got=%b exp=0", if8.req_ready); end
    wait_done(1'b0, 100, td, ok);
    total++; if (td - ta !== 3 * HOLD) begin bad++; $display("FAIL char8_done_latency got=%0d exp=%0d", td - ta, 3 * HOLD); end
    total++; if (rs8 !== 1'b0) begin bad++; $display("FAIL char8_done_rs got=%b exp=0", rs8); end
    @(negedge clk);
    total++; if (if8.done_tick !== 1'b0) begin bad++; $display("FAIL char8_done_width got=%b exp=0", if8.done_tick); end
    total++; if (if8.req_ready !== 1'b1) begin bad++; $display("FAIL char8_ready_after got=%b exp=1", if8.req_ready); end
  endtask

  task automatic test_cursor();
    logic [1:0] rows[4] = '{2'd1, 2'd3, 2'd0, 2'd2};
    logic [5:0] cols[4] = '{6'd5, 6'd20, 6'd0, 6'd3};
    logic [7:0] exps[4] = '{8'hC5, 8'hCF, 8'h80, 8'hC3};
    logic [7:0] d; logic rs; int ta, tr, tf, td; bit ok;
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, 2'b01, 8'h00, rows[i], cols[i], ta, ok);
      catch_pulse(1'b0, 40, d, rs, tr, tf, ok);
      total++; if (d !== exps[i]) begin bad++; $display("FAIL cursor%0d_data got=%h exp=%h", i, d, exps[i]); end
      total++; if (rs !== 1'b0)   begin bad++; $display("FAIL cursor%0d_rs got=%b exp=0", i, rs); end
      wait_done(1'b0, 100, td, ok);
      total++; if (td - ta !== 3 * HOLD) begin bad++; $display("FAIL cursor%0d_done got=%0d exp=%0d", i, td - ta, 3 * HOLD); end
      @(negedge clk);
    end
  endtask

  task automatic test_char4();
    logic [7:0] d; logic rs; int ta, tr, tf, td; bit ok;
    do_req(1'b1, 2'b00, 8'hA7, 2'b00, 6'd0, ta, ok);
    catch_pulse(1'b1, 40, d, rs, tr, tf, ok);
    total++; if (d !== 8'hA0) begin bad++; $display("FAIL char4_hi got=%h exp=a0", d); end
    total++; if (rs !== 1'b1) begin bad++; $display("FAIL char4_hi_rs got=%b exp=1", rs); end
    catch_pulse(1'b1, 40, d, rs, tr, tf, ok);
    total++; if (d !== 8'h70) begin bad++; $display("FAIL char4_lo got=%h exp=70", d); end
    total++; if (tr - ta !== 4 * HOLD) begin bad++; $display("FAIL char4_lo_rise got=%0d exp=%0d", tr - ta, 4 * HOLD); end
    wait_done(1'b1, 100, td, ok);
    total++; if (td - ta !== 6 * HOLD) begin bad++; $display("FAIL char4_done got=%0d exp=%0d", td - ta, 6 * HOLD); end
    @(negedge clk);
    do_req(1'b1, 2'b11, 8'h00, 2'b00, 6'd0, ta, ok);
    wait_done(1'b1, 200, td, ok);
    total++; if (td - ta !== 6 * HOLD + CLR) begin bad++; $display("FAIL clear4_done got=%0d exp=%0d", td - ta, 6 * HOLD + CLR); end
    @(negedge clk);
  endtask

  task automatic test_clear();
    logic [1:0] kinds[3] = '{2'b11, 2'b10, 2'b10};
    logic [7:0] dats[3]  = '{8'h55, 8'h02, 8'h1C};
    logic [7:0] exps[3]  = '{8'h01, 8'h02, 8'h1C};
    int lat[3] = '{3 * HOLD + CLR, 3 * HOLD + CLR, 3 * HOLD};
    logic [7:0] d; logic rs; int ta, tr, tf, td; bit ok;
    for (int i = 0; i < 3; i++) begin
      do_req(1'b0, kinds[i], dats[i], 2'b00, 6'd0, ta, ok);
      catch_pulse(1'b0, 40, d, rs, tr, tf, ok);
      total++; if (d !== exps[i]) begin bad++; $display("FAIL clear%0d_data got=%h exp=%h", i, d, exps[i]); end
      total++; if (rs !== 1'b0)   begin bad++; $display("FAIL clear%0d_rs got=%b exp=0", i, rs); end
      wait_done(1'b0, 200, td, ok);
      total++; if (td - ta !== lat[i]) begin bad++; $display("FAIL clear%0d_done got=%0d exp=%0d", i, td - ta, lat[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] d; logic rs; int ta, tr, tf, td; bit ok;
    do_req(1'b0, 2'b01, 8'h00, 2'b00, 6'd15, ta, ok);
    wait_done(1'b0, 100, td, ok);
    @(negedge clk);
    do_req(1'b0, 2'b00, 8'h5A, 2'b00, 6'd0, ta, ok);
    catch_pulse(1'b0, 40, d, rs, tr, tf, ok);
    total++; if (d !== 8'h5A) begin bad++; $display("FAIL wrap_char got=%h exp=5a", d); end
    total++; if (rs !== 1'b1) begin bad++; $display("FAIL wrap_char_rs got=%b exp=1", rs); end
`ifdef LCD_AUTOWRAP_EN
    catch_pulse(1'b0, 40, d, rs, tr, tf, ok);
    total++; if (d !== 8'hC0) begin bad++; $display("FAIL wrap_addr got=%h exp=c0", d); end
    total++; if (rs !== 1'b0) begin bad++; $display("FAIL wrap_addr_rs got=%b exp=0", rs); end
    wait_done(1'b0, 100, td, ok);
    total++; if (td - ta !== 6 * HOLD) begin bad++; $display("FAIL wrap_done got=%0d exp=%0d", td - ta, 6 * HOLD); end
`else
    wait_done(1'b0, 100, td, ok);
    total++; if (td - ta !== 3 * HOLD) begin bad++; $display("FAIL nowrap_done got=%0d exp=%0d", td - ta, 3 * HOLD); end
    catch_pulse(1'b0, 20, d, rs, tr, tf, ok);
    total++; if (ok !== 1'b0) begin bad++; $display("FAIL nowrap_extra_strobe got=%h exp=none", d); end
`endif
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [7:0] d; logic rs; int ta, tr, tf, t_rel; bit ok;
    do_req(1'b0, 2'b00, 8'h33, 2'b00, 6'd0, ta, ok);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (en8) break;
    end
    total++; if (en8 !== 1'b1) begin bad++; $display("FAIL rstmid_en_high got=%b exp=1", en8); end
    rst8_n = 1'b0;
    @(negedge clk);
    total++; if (en8 !== 1'b0)           begin bad++; $display("FAIL rstmid_en_drop got=%b exp=0", en8); end
    total++; if (if8.init_done !== 1'b0) begin bad++; $display("FAIL rstmid_init got=%b exp=0", if8.init_done); end
    total++; if (if8.req_ready !== 1'b0) begin bad++; $display("FAIL rstmid_ready got=%b exp=0", if8.req_ready); end
    total++; if (d8 !== 8'h00)           begin bad++; $display("FAIL rstmid_data got=%h exp=00", d8); end
    rst8_n = 1'b1;
    t_rel = cyc;
    catch_pulse(1'b0, 60, d, rs, tr, tf, ok);
    total++; if (d !== 8'h38) begin bad++; $display("FAIL rstmid_reinit got=%h exp=38", d); end
    total++; if (tr - t_rel !== POR + HOLD) begin bad++; $display("FAIL rstmid_reinit_time got=%0d exp=%0d", tr - t_rel, POR + HOLD); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init8();
    test_char8();
    test_cursor();
    test_clear();
    test_wrap();
    test_init4();
    test_char4();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
